// File: rtl/hdmi_infoframe_pkg.sv
// Shared InfoFrame constants, parser state and audio field layout.
// Used by the audio InfoFrame generator and parser.
package hdmi_infoframe_pkg;

  localparam logic [7:0] IF_TYPE_AUDIO = 8'h84;
  localparam logic [7:0] IF_TYPE_AVI   = 8'h82;
  localparam logic [7:0] IF_TYPE_SPD   = 8'h83;

  localparam int HB_COUNT = 3;
  localparam int PB_COUNT = 28;

  localparam logic [4:0] IF_MAX_LEN = 5'd27;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_HEADER,
    PS_BODY
  } parse_state_e;

  // PB1 / PB2 / PB5 field positions
  localparam int PB1_CT_LSB  = 4;
  localparam int PB1_CC_LSB  = 0;
  localparam int PB2_SF_LSB  = 2;
  localparam int PB2_SS_LSB  = 0;
  localparam int PB5_DMI_BIT = 7;
  localparam int PB5_LSV_LSB = 3;
  localparam int PB5_LFE_LSB = 0;

  typedef struct packed {
    logic [3:0] coding_type;
    logic [2:0] channel_count;
    logic [2:0] sampling_frequency;
    logic [1:0] sample_size;
    logic [7:0] channel_allocation;
    logic       down_mix_inhibited;
    logic [3:0] level_shift_value;
    logic [1:0] lfe_playback_level;
  } audio_fields_t;

endpackage

// File: rtl/infoframe_checksum.sv
// Running mod-256 InfoFrame byte sum; is_zero_o reflects the sum
// after this cycle's clear/load/add takes effect.
module infoframe_checksum (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  output logic       is_zero_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i)
      sum_d = 8'd0;
    else if (load_i)
      sum_d = data_i;
    else if (add_i)
      sum_d = sum_q + data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      sum_q <= 8'd0;
    else
      sum_q <= sum_d;
  end

  assign is_zero_o = (sum_d == 8'd0);

endmodule

// File: rtl/audio_info_frame_parser.sv
// Audio InfoFrame receiver: header/checksum validation and
// latching of decoded audio fields for the audio sink.
module audio_info_frame_parser
  import hdmi_infoframe_pkg::*;
#(
  parameter logic [7:0] EXPECTED_VERSION = 8'd1,
  parameter logic [4:0] MIN_LENGTH       = 5'd10
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_sop,
  output logic [3:0] coding_type,
  output logic [2:0] channel_count,
  output logic [2:0] sampling_frequency,
  output logic [1:0] sample_size,
  output logic [7:0] channel_allocation,
  output logic       down_mix_inhibited,
  output logic [3:0] level_shift_value,
  output logic [1:0] lfe_playback_level,
  output logic       fields_valid,
  output logic       frame_done,
  output logic       checksum_error,
  output logic       header_error
);

  parse_state_e  state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic          hdr_ok_q, hdr_ok_d;
  logic [4:0]    len_q, len_d;
  audio_fields_t shadow_q, shadow_d;
  audio_fields_t fields_q, fields_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          cerr_q, cerr_d;
  logic          herr_q, herr_d;

  logic          ck_clear;
  logic          ck_load;
  logic          ck_add;
  logic          ck_zero;
  logic [4:0]    pb;
  logic          len_ok;

  assign pb = idx_q - 5'(HB_COUNT);

  assign len_ok = (byte_in[4:0] >= MIN_LENGTH)
               && (byte_in[4:0] <= IF_MAX_LEN);

  infoframe_checksum u_cksum (
    .clk_i     (clk_pixel),
    .rst_i     (reset),
    .clear_i   (ck_clear),
    .load_i    (ck_load),
    .add_i     (ck_add),
    .data_i    (byte_in),
    .is_zero_o (ck_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hdr_ok_d = hdr_ok_q;
    len_d    = len_q;
    shadow_d = shadow_q;
    fields_d = fields_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    cerr_d   = 1'b0;
    herr_d   = 1'b0;
    ck_clear = 1'b0;
    ck_load  = 1'b0;
    ck_add   = 1'b0;

    if (byte_valid && byte_sop) begin
      ck_load  = 1'b1;
      idx_d    = 5'd1;
      hdr_ok_d = (byte_in == IF_TYPE_AUDIO);
      state_d  = PS_HEADER;
    end else if (byte_valid) begin
      unique case (state_q)
        PS_IDLE: ;
        PS_HEADER: begin
          ck_add = 1'b1;
          idx_d  = idx_q + 5'd1;
          if (idx_q == 5'd1) begin
            hdr_ok_d = hdr_ok_q
                    && (byte_in == EXPECTED_VERSION);
          end else if (hdr_ok_q
                    && (byte_in[7:5] == 3'd0)
                    && len_ok) begin
            len_d   = byte_in[4:0];
            state_d = PS_BODY;
          end else begin
            herr_d   = 1'b1;
            ck_clear = 1'b1;
            state_d  = PS_IDLE;
          end
        end
        PS_BODY: begin
          ck_add = (pb <= len_q);
          idx_d  = idx_q + 5'd1;
          unique case (pb)
            5'd1: begin
              shadow_d.coding_type =
                byte_in[PB1_CT_LSB +: 4];
              shadow_d.channel_count =
                byte_in[PB1_CC_LSB +: 3];
            end
            5'd2: begin
              shadow_d.sampling_frequency =
                byte_in[PB2_SF_LSB +: 3];
              shadow_d.sample_size =
                byte_in[PB2_SS_LSB +: 2];
            end
            5'd4: shadow_d.channel_allocation = byte_in;
            5'd5: begin
              shadow_d.down_mix_inhibited =
                byte_in[PB5_DMI_BIT];
              shadow_d.level_shift_value =
                byte_in[PB5_LSV_LSB +: 4];
              shadow_d.lfe_playback_level =
                byte_in[PB5_LFE_LSB +: 2];
            end
            default: ;
          endcase
          // Decision uses the sum including this byte.
          if (pb == 5'(PB_COUNT - 1)) begin
            state_d = PS_IDLE;
            if (ck_zero) begin
              fields_d = shadow_q;
              valid_d  = 1'b1;
              done_d   = 1'b1;
            end else begin
              cerr_d = 1'b1;
            end
          end
        end
        default: state_d = PS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q  <= PS_IDLE;
      idx_q    <= 5'd0;
      hdr_ok_q <= 1'b0;
      len_q    <= 5'd0;
      shadow_q <= '0;
      fields_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      cerr_q   <= 1'b0;
      herr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hdr_ok_q <= hdr_ok_d;
      len_q    <= len_d;
      shadow_q <= shadow_d;
      fields_q <= fields_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      cerr_q   <= cerr_d;
      herr_q   <= herr_d;
    end
  end

  assign coding_type        = fields_q.coding_type;
  assign channel_count      = fields_q.channel_count;
  assign sampling_frequency = fields_q.sampling_frequency;
  assign sample_size        = fields_q.sample_size;
  assign channel_allocation = fields_q.channel_allocation;
  assign down_mix_inhibited = fields_q.down_mix_inhibited;
  assign level_shift_value  = fields_q.level_shift_value;
  assign lfe_playback_level = fields_q.lfe_playback_level;
  assign fields_valid       = valid_q;
  assign frame_done         = done_q;
  assign checksum_error     = cerr_q;
  assign header_error       = herr_q;

endmodule

// File: tb/tb_audio_info_frame_parser.sv
// Randomized self-checking bench for the audio InfoFrame parser
// against a frame-level reference model.
module tb_audio_info_frame_parser;

  typedef logic [7:0] frame_t [31];

  localparam int K_HDR  = 0;
  localparam int K_CK   = 1;
  localparam int K_GOOD = 2;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_sop;
  logic [3:0] coding_type;
  logic [2:0] channel_count;
  logic [2:0] sampling_frequency;
  logic [1:0] sample_size;
  logic [7:0] channel_allocation;
  logic       down_mix_inhibited;
  logic [3:0] level_shift_value;
  logic [1:0] lfe_playback_level;
  logic       fields_valid;
  logic       frame_done;
  logic       checksum_error;
  logic       header_error;

  audio_info_frame_parser dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .byte_in            (byte_in),
    .byte_valid         (byte_valid),
    .byte_sop           (byte_sop),
    .coding_type        (coding_type),
    .channel_count      (channel_count),
    .sampling_frequency (sampling_frequency),
    .sample_size        (sample_size),
    .channel_allocation (channel_allocation),
    .down_mix_inhibited (down_mix_inhibited),
    .level_shift_value  (level_shift_value),
    .lfe_playback_level (lfe_playback_level),
    .fields_valid       (fields_valid),
    .frame_done         (frame_done),
    .checksum_error     (checksum_error),
    .header_error       (header_error)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_tests = 0;
  int n_fail  = 0;

  int e_ct, e_cc, e_sf, e_ss, e_ca;
  int e_dmi, e_lsv, e_lfe, e_valid;
  int x_done = 0, x_cerr = 0, x_herr = 0;
  int a_done = 0, a_cerr = 0, a_herr = 0;
  logic prev_any = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk_pixel) begin
    logic any;
    any = frame_done | checksum_error | header_error;
    a_done += int'(frame_done);
    a_cerr += int'(checksum_error);
    a_herr += int'(header_error);
    if (any) begin
      chk("pulse_excl",
          32'(frame_done) + 32'(checksum_error)
          + 32'(header_error), 1);
      chk("pulse_width", 32'(prev_any), 0);
    end
    prev_any = any;
  end

  task automatic clear_exp();
    e_ct = 0; e_cc = 0; e_sf = 0; e_ss = 0; e_ca = 0;
    e_dmi = 0; e_lsv = 0; e_lfe = 0; e_valid = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ct"},  32'(coding_type),        e_ct);
    chk({tag, "_cc"},  32'(channel_count),      e_cc);
    chk({tag, "_sf"},  32'(sampling_frequency), e_sf);
    chk({tag, "_ss"},  32'(sample_size),        e_ss);
    chk({tag, "_ca"},  32'(channel_allocation), e_ca);
    chk({tag, "_dmi"}, 32'(down_mix_inhibited), e_dmi);
    chk({tag, "_lsv"}, 32'(level_shift_value),  e_lsv);
    chk({tag, "_lfe"}, 32'(lfe_playback_level), e_lfe);
    chk({tag, "_vld"}, 32'(fields_valid),       e_valid);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_ndone"}, a_done, x_done);
    chk({tag, "_ncerr"}, a_cerr, x_cerr);
    chk({tag, "_nherr"}, a_herr, x_herr);
  endtask

  function automatic int model_kind(input frame_t f);
    int len, s;
    logic [7:0] hb2;
    hb2 = f[2];
    if (f[0] != 8'h84 || f[1] != 8'h01) return K_HDR;
    if (hb2[7:5] != 3'd0) return K_HDR;
    len = int'(hb2[4:0]);
    if (len < 10 || len > 27) return K_HDR;
    s = 0;
    for (int i = 0; i <= len + 3; i++) s += int'(f[i]);
    return (s % 256 == 0) ? K_GOOD : K_CK;
  endfunction

  task automatic model_latch(input frame_t f);
    logic [7:0] p1, p2, p5;
    p1 = f[4]; p2 = f[5]; p5 = f[8];
    e_ct  = int'(p1[7:4]);
    e_cc  = int'(p1[2:0]);
    e_sf  = int'(p2[4:2]);
    e_ss  = int'(p2[1:0]);
    e_ca  = int'(f[7]);
    e_dmi = int'(p5[7]);
    e_lsv = int'(p5[6:3]);
    e_lfe = int'(p5[1:0]);
    e_valid = 1;
  endtask

  function automatic frame_t nominal();
    frame_t f;
    for (int i = 0; i < 31; i++) f[i] = 8'h00;
    f[0] = 8'h84; f[1] = 8'h01; f[2] = 8'h0A;
    f[3] = 8'h70; f[4] = 8'h01;
    return f;
  endfunction

  function automatic frame_t fix_sum(input frame_t f);
    int len, s;
    logic [7:0] hb2;
    hb2 = f[2];
    len = int'(hb2[4:0]);
    s = 0;
    for (int i = 0; i <= len + 3; i++)
      if (i != 3) s += int'(f[i]);
    f[3] = 8'((256 - (s % 256)) % 256);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b,
                           input logic s, input int gap);
    repeat (gap) begin
      @(posedge clk_pixel); #1;
    end
    byte_in = b; byte_valid = 1'b1; byte_sop = s;
    @(posedge clk_pixel); #1;
    byte_valid = 1'b0; byte_sop = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic send_part(input frame_t f, input int n);
    for (int i = 0; i < n; i++)
      send_byte(f[i], i == 0, 0);
  endtask

  task automatic run_frame(input frame_t f, input int maxgap,
                           input int settle);
    int kind, g;
    kind = model_kind(f);
    for (int i = 0; i < 31; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      send_byte(f[i], i == 0, g);
      if (i == 2)
        chk("herr_pulse", 32'(header_error), 32'(kind == K_HDR));
    end
    chk("done_pulse", 32'(frame_done), 32'(kind == K_GOOD));
    chk("cerr_pulse", 32'(checksum_error), 32'(kind == K_CK));
    case (kind)
      K_GOOD: begin model_latch(f); x_done++; end
      K_CK:   x_cerr++;
      default: x_herr++;
    endcase
    check_outputs("post");
    if (settle > 0) begin
      repeat (settle) begin @(posedge clk_pixel); #1; end
      check_counts("cnt");
    end
  endtask

  initial begin
    frame_t f, g;
    int mode;
    reset = 1'b1; byte_in = 8'h00;
    byte_valid = 1'b0; byte_sop = 1'b0;
    clear_exp();
    repeat (3) @(posedge clk_pixel);
    #1;
    check_outputs("rst");
    chk("rst_pulses",
        32'({frame_done, checksum_error, header_error}), 0);
    reset = 1'b0;
    @(posedge clk_pixel); #1;

    // Bad checksum before any good frame, then the good one
    f = nominal(); f[3] = 8'h71;
    run_frame(f, 0, 2);
    f = nominal();
    run_frame(f, 0, 2);

    // Header faults: wrong type, length 28, length 9
    f = nominal(); f[0] = 8'h82;
    run_frame(f, 0, 2);
    f = nominal(); f[2] = 8'h1C;
    run_frame(f, 0, 2);
    f = nominal(); f[2] = 8'h09;
    run_frame(f, 0, 2);

    // Abort at PB10 by a new sop
    f = nominal();
    send_part(f, 13);
    g = nominal(); g[3] = 8'hC5; g[7] = 8'h13; g[8] = 8'h98;
    run_frame(g, 0, 2);

    // Bytes beyond length, with random gaps
    f = nominal(); f[23] = 8'hFF;
    run_frame(f, 5, 3);

    // Back-to-back at full rate
    f = nominal(); f[5] = 8'h0E;
    f = fix_sum(f);
    run_frame(f, 0, 0);
    g = nominal(); g[7] = 8'h2A;
    g = fix_sum(g);
    run_frame(g, 0, 2);

    // Async reset at PB15
    f = nominal(); f[4] = 8'hF3;
    f = fix_sum(f);
    send_part(f, 18);
    byte_in = f[18]; byte_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    clear_exp();
    check_outputs("async_rst");
    byte_valid = 1'b0;
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    @(posedge clk_pixel); #1;
    check_counts("rst_cnt");
    f = nominal(); f[8] = 8'h5B;
    f = fix_sum(f);
    run_frame(f, 0, 2);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 31; i++) f[i] = 8'($urandom);
      f[0] = 8'h84; f[1] = 8'h01;
      f[2] = {3'd0, 5'($urandom_range(10, 27))};
      f = fix_sum(f);
      mode = int'($urandom_range(0, 5));
      if (mode == 0) f[3] = f[3] ^ 8'($urandom_range(1, 255));
      if (mode == 1) f[2] = 8'($urandom);
      if (mode == 2) f[1] = 8'($urandom_range(2, 255));
      run_frame(f, int'($urandom_range(0, 2)),
                (n % 3 == 0 && n != 23) ? 0 : 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_info_frame_parser.md
Name: audio_info_frame_parser

Overview:
- Receive-side counterpart of the audio InfoFrame generator (CEA-861-D §6.6, HDMI 1.4 §8.2.2).
- Consumes the 31-byte InfoFrame byte stream (HB0..HB2, PB0..PB27) from the receiver's data-island packet deserializer.
- Validates header and checksum, then latches the decoded audio fields for the downstream audio sink and channel mapper.

Parameters:
- EXPECTED_VERSION, 8'd1: required HB1 value.
- MIN_LENGTH, 5'd10: minimum accepted HB2[4:0]; maximum is fixed at 27.

Ports:
- clk_pixel  input  1  pixel clock; all logic in this domain.
- reset  input  1  asynchronous, active-high.
- byte_in  input  8  InfoFrame byte.
- byte_valid  input  1  byte_in valid this cycle; gaps allowed anywhere.
- byte_sop  input  1  qualified by byte_valid; marks byte_in as HB0.
- coding_type  output  4  PB1[7:4].
- channel_count  output  3  PB1[2:0] (channels minus 1).
- sampling_frequency  output  3  PB2[4:2].
- sample_size  output  2  PB2[1:0].
- channel_allocation  output  8  PB4.
- down_mix_inhibited  output  1  PB5[7].
- level_shift_value  output  4  PB5[6:3].
- lfe_playback_level  output  2  PB5[1:0].
- fields_valid  output  1  sticky; set by first good frame.
- frame_done  output  1  one-cycle pulse, good frame latched.
- checksum_error  output  1  one-cycle pulse.
- header_error  output  1  one-cycle pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, byte index 0, checksum accumulator 0.
- States: IDLE, HEADER, BODY. 5-bit byte index counts accepted bytes; it holds when byte_valid=0.
- A byte is "accepted" when byte_valid=1.
- byte_valid&byte_sop in any state: abort any frame in progress (no pulse for it), take the byte as HB0, accumulator := byte_in, index := 1, go to HEADER.
- byte_valid without byte_sop in IDLE: ignored.
- HEADER: accumulate HB1 and HB2. On HB2 acceptance, check all of:
  - HB0 == 8'h84;
  - HB1 == EXPECTED_VERSION;
  - HB2[7:5] == 0;
  - MIN_LENGTH <= HB2[4:0] <= 27.
- Header check fails: header_error pulses the next cycle, go to IDLE, and all further non-sop bytes are ignored.
- Header check passes: store length L, go to BODY.
- BODY: PB0..PB27 are consumed in order.
  - PB0..PB(L) are added mod 256 to the accumulator.
  - PB(L+1)..PB27 are consumed but not checked.
  - PB1, PB2, PB4 and PB5 are captured into shadow registers, not into the outputs.
  - Reserved bits (PB1[3], PB2[7:5], PB3, PB5[2]) are ignored except for their checksum contribution.
- On acceptance of PB27, go to IDLE. On the following cycle, exactly one of these happens:
  - accumulator == 0: shadows are copied to the outputs, fields_valid := 1, frame_done pulses. Outputs update on the same edge as frame_done.
  - accumulator != 0: checksum_error pulses and the outputs keep their previous values.
- Latency: outputs and pulses appear 1 cycle after the PB27 byte. The minimum frame-to-frame spacing is 31 accepted bytes; back-to-back frames at full rate are supported.
- Arithmetic: accumulator is 8 bits and wraps; there is no sticky error.
- Reset mid-frame: everything returns to reset values, with no pulses.
- The three pulses are mutually exclusive and never last more than one cycle.

Decomposition:
- Shared package hdmi_infoframe_pkg holds:
  - the InfoFrame type codes (AUDIO = 8'h84, AVI = 8'h82, SPD = 8'h83);
  - the header byte count 3 and PB count 28;
  - the max length 27;
  - the parser state enum;
  - bitfield positions of the PB1/PB2/PB5 fields.
- The generator will reuse the constants from this package.
- One sub-module: infoframe_checksum, an 8-bit running mod-256 sum with clear/load/add inputs and an is_zero output. It is reusable by future AVI/SPD parsers.

Test Plan:
- Nominal frame: HB=84 01 0A, PB0=70, PB1=01, others 00 → frame_done exactly 1 cycle after PB27; channel_count=1, all other fields 0, fields_valid=1.
- Same frame with PB0=71 → checksum_error pulse only; fields_valid stays 0 and outputs stay 0. Then resend with PB0=70 → frame_done.
- HB0=82 → header_error pulse 1 cycle after HB2; no frame_done for the remaining 28 bytes. Repeat with HB2=1C (length 28) and with HB2=09 → header_error in both cases.
- Nominal frame aborted by byte_sop at PB10, immediately followed by a valid frame with PB4=13, PB5=98, PB0=C5 → a single frame_done with channel_allocation=13, down_mix_inhibited=1, level_shift_value=3, lfe_playback_level=0.
- Nominal frame with PB20=FF (beyond L=10) and random byte_valid gaps of 0–5 cycles → frame_done; the result is identical to the gap-free case.
- reset asserted asynchronously at PB15 → outputs 0 immediately with no pulse. A following full frame is decoded normally.
